// File: rtl/out_mux_pkg.sv
// ============================================================================
//  out_mux_pkg : shared types and helpers for the packet-atomic output merger
//  Revision    : 1.0
// ============================================================================
`default_nettype none

package out_mux_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_e;

    // Ceiling log2, never below 1 so that derived vectors keep a legal width.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = 1;
        while (v < value) begin
            v = v << 1;
            r = r + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

    localparam int MAX_CH = 8;
    localparam int PTR_W  = clog2(MAX_CH);

endpackage

`default_nettype wire

// File: rtl/rr_pkt_arbiter.sv
// ============================================================================
//  rr_pkt_arbiter : round-robin grant of whole packets across N_CH channels
//  Revision       : 1.0
// ============================================================================
`default_nettype none

module rr_pkt_arbiter
    import out_mux_pkg::*;
#(
    parameter int N_CH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] ch_empty,
    input  logic [N_CH-1:0] ch_last,
    input  logic            stall,
    output logic [N_CH-1:0] gnt,
    output logic [N_CH-1:0] ch_rd_en,
    output logic            pop,
    output logic            pop_last
);

    arb_state_e       state_q, state_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [PTR_W-1:0] idx_q, idx_d;
    logic             found;

    always_comb begin
        gnt = '0;
        if (state_q == ST_GRANT) begin
            for (int k = 0; k < N_CH; k++) begin
                if (idx_q == PTR_W'(k)) gnt[k] = 1'b1;
            end
        end
    end

    assign ch_rd_en = gnt & ~ch_empty & {N_CH{~stall}};
    assign pop      = |ch_rd_en;
    assign pop_last = |(ch_rd_en & ch_last);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        found   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // Scan offsets from ptr so the first hit is the round-robin winner.
                for (int i = 0; i < N_CH; i++) begin
                    for (int k = 0; k < N_CH; k++) begin
                        if (!found && !ch_empty[k] && (k == (int'(ptr_q) + i) % N_CH)) begin
                            found = 1'b1;
                            idx_d = PTR_W'(k);
                        end
                    end
                end
                if (found) state_d = ST_GRANT;
            end
            ST_GRANT: begin
                if (pop_last) begin
                    ptr_d   = (int'(idx_q) == N_CH - 1) ? '0 : idx_q + PTR_W'(1);
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/output_pkt_limit_mux.sv
// ============================================================================
//  output_pkt_limit_mux : packet-atomic N-channel merger with output-limit mode
//  Revision             : 1.0
// ============================================================================
`default_nettype none

module output_pkt_limit_mux
    import out_mux_pkg::*;
#(
    parameter int N_CH    = 4,
    parameter int WIDTH   = 16,
    parameter int DEPTH   = 2048,
    parameter int LIMIT_W = 16
) (
    input  logic                  IFCLK,
    input  logic                  RESET_N,
    input  logic [N_CH*WIDTH-1:0] ch_din,
    input  logic [N_CH-1:0]       ch_last,
    input  logic [N_CH-1:0]       ch_empty,
    output logic [N_CH-1:0]       ch_rd_en,
    output logic [WIDTH-1:0]      dout,
    output logic                  empty,
    input  logic                  rd_en,
    input  logic                  mode_limit,
    input  logic                  reg_output_limit,
    output logic [LIMIT_W-1:0]    output_limit,
    output logic                  output_limit_not_done,
    output logic                  err_underrun,
    output logic                  err_pkt_overflow
);

    localparam int AW = clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [N_CH-1:0]    gnt;
    logic               pop, pop_last;
    logic [WIDTH-1:0]   wr_data;
    logic               buf_full, rd_fire;

    logic [WIDTH-1:0]   buf_mem [DEPTH];
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      count_q, count_d;
    logic [CW-1:0]      pkt_cnt_q, pkt_cnt_d;
    logic [CW-1:0]      committed_q, committed_d;
    logic [CW-1:0]      remaining_q, remaining_d;
    logic [LIMIT_W-1:0] output_limit_q, output_limit_d;
    logic [WIDTH-1:0]   dout_q, dout_d;
    logic               not_done_q, not_done_d;
    logic               mode_limit_q;
    logic               err_underrun_q, err_underrun_d;
    logic               err_ovf_q, err_ovf_d;

    rr_pkt_arbiter #(
        .N_CH (N_CH)
    ) u_arb (
        .clk      (IFCLK),
        .rst_n    (RESET_N),
        .ch_empty (ch_empty),
        .ch_last  (ch_last),
        .stall    (buf_full),
        .gnt      (gnt),
        .ch_rd_en (ch_rd_en),
        .pop      (pop),
        .pop_last (pop_last)
    );

    always_comb begin
        wr_data = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (gnt[k]) wr_data = ch_din[k*WIDTH +: WIDTH];
        end
    end

    assign buf_full = (count_q == CW'(DEPTH));
    assign empty    = mode_limit ? (remaining_q == '0) : (committed_q == '0);
    assign rd_fire  = rd_en & ~empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(pop);
        rd_ptr_d = rd_ptr_q + AW'(rd_fire);
        count_d  = count_q + CW'(pop) - CW'(rd_fire);

        pkt_cnt_d = pkt_cnt_q;
        if (pop_last)  pkt_cnt_d = '0;
        else if (pop)  pkt_cnt_d = pkt_cnt_q + CW'(1);

        committed_d = committed_q - CW'(rd_fire);
        if (pop_last) committed_d = committed_d + pkt_cnt_q + CW'(1);

        remaining_d    = remaining_q;
        output_limit_d = output_limit_q;
        if (mode_limit_q && !mode_limit) begin
            remaining_d = '0;
        end else if (reg_output_limit && mode_limit && (remaining_q == '0)) begin
            remaining_d    = committed_q;
            output_limit_d = LIMIT_W'(committed_q);
        end else if (rd_fire && (remaining_q != '0)) begin
            remaining_d = remaining_q - CW'(1);
        end
        not_done_d = (remaining_d != '0);

        err_underrun_d = err_underrun_q | (rd_en & empty);
        err_ovf_d      = err_ovf_q | (buf_full & (committed_q == '0));

        // Registered head-of-queue; a same-cycle write to the new head is forwarded.
        if (count_d == '0)                         dout_d = '0;
        else if (pop && (wr_ptr_q == rd_ptr_d))    dout_d = wr_data;
        else                                       dout_d = buf_mem[rd_ptr_d];
    end

    always_ff @(posedge IFCLK) begin
        if (pop) buf_mem[wr_ptr_q] <= wr_data;
    end

    always_ff @(posedge IFCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            pkt_cnt_q      <= '0;
            committed_q    <= '0;
            remaining_q    <= '0;
            output_limit_q <= '0;
            dout_q         <= '0;
            not_done_q     <= 1'b0;
            mode_limit_q   <= 1'b0;
            err_underrun_q <= 1'b0;
            err_ovf_q      <= 1'b0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            pkt_cnt_q      <= pkt_cnt_d;
            committed_q    <= committed_d;
            remaining_q    <= remaining_d;
            output_limit_q <= output_limit_d;
            dout_q         <= dout_d;
            not_done_q     <= not_done_d;
            mode_limit_q   <= mode_limit;
            err_underrun_q <= err_underrun_d;
            err_ovf_q      <= err_ovf_d;
        end
    end

    assign dout                  = dout_q;
    assign output_limit          = output_limit_q;
    assign output_limit_not_done = not_done_q;
    assign err_underrun          = err_underrun_q;
    assign err_pkt_overflow      = err_ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_output_pkt_limit_mux.sv
// ============================================================================
//  tb_output_pkt_limit_mux : directed self-checking bench for output_pkt_limit_mux
//  Revision                : 1.0
// ============================================================================
`default_nettype none

module tb_output_pkt_limit_mux;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] ch_din;
    logic [3:0]  ch_last, ch_empty, ch_rd_en;
    logic [15:0] dout;
    logic        empty, rd_en, mode_limit, reg_output_limit;
    logic [15:0] output_limit;
    logic        not_done, err_ur, err_ovf;

    output_pkt_limit_mux #(
        .N_CH    (4),
        .WIDTH   (16),
        .DEPTH   (16),
        .LIMIT_W (16)
    ) dut (
        .IFCLK                 (clk),
        .RESET_N               (rst_n),
        .ch_din                (ch_din),
        .ch_last               (ch_last),
        .ch_empty              (ch_empty),
        .ch_rd_en              (ch_rd_en),
        .dout                  (dout),
        .empty                 (empty),
        .rd_en                 (rd_en),
        .mode_limit            (mode_limit),
        .reg_output_limit      (reg_output_limit),
        .output_limit          (output_limit),
        .output_limit_not_done (not_done),
        .err_underrun          (err_ur),
        .err_pkt_overflow      (err_ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        mode;
        logic        pulse;
        logic        rd;
        logic        exp_empty;
        logic        exp_nd;
        logic [15:0] exp_ol;
    } vec_t;

    vec_t        tbl [13];
    logic [16:0] chm [4][128];
    int          hd [4];
    int          tl [4];
    logic [15:0] obuf [64];
    int          ocnt;
    int          glog [64];
    int          gcnt;
    int          nvec = 0;
    int          nerr = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic refresh();
        for (int k = 0; k < 4; k++) begin
            ch_empty[k] = (hd[k] == tl[k]);
            {ch_last[k], ch_din[k*16 +: 16]} = chm[k][hd[k]];
        end
    endtask

    task automatic push(input int k, input logic [15:0] d, input logic l);
        chm[k][tl[k]] = {l, d};
        tl[k]++;
        refresh();
    endtask

    task automatic clear_src();
        for (int k = 0; k < 4; k++) begin
            hd[k] = 0;
            tl[k] = 0;
        end
        refresh();
    endtask

    // One clock: sample pops/reads before the edge, retire them after it.
    task automatic cyc();
        logic [3:0] pm;
        @(negedge clk);
        pm = ch_rd_en;
        if (rd_en && !empty && ocnt < 64) begin
            obuf[ocnt] = dout;
            ocnt++;
        end
        for (int k = 0; k < 4; k++) begin
            if (pm[k] && gcnt < 64) begin
                glog[gcnt] = k;
                gcnt++;
            end
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) if (pm[k]) hd[k]++;
        refresh();
        #1;
    endtask

    task automatic drain(input int n);
        int target;
        int guard;
        target = ocnt + n;
        guard  = 0;
        rd_en  = 1'b1;
        while (ocnt < target && guard < 50) begin
            cyc();
            guard++;
        end
        rd_en = 1'b0;
        chk("drain_count", ocnt, target);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'd10};
        for (int i = 1; i <= 5; i++) tbl[i] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 16'd10};
        tbl[6]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 16'd10};
        for (int i = 7; i <= 9; i++) tbl[i] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 16'd10};
        tbl[10] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'd10};
        tbl[11] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'd10};
        tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd10};

        for (int k = 0; k < 4; k++)
            for (int j = 0; j < 128; j++) chm[k][j] = '0;
        rst_n = 1'b0;
        rd_en = 1'b0;
        mode_limit = 1'b0;
        reg_output_limit = 1'b0;
        ocnt = 0;
        gcnt = 0;
        clear_src();

        // Reset state
        cyc(); cyc();
        chk("rst_ch_rd_en", ch_rd_en, 4'b0000);
        chk("rst_empty", empty, 1'b1);
        chk("rst_dout", dout, 16'h0);
        chk("rst_output_limit", output_limit, 16'h0);
        chk("rst_not_done", not_done, 1'b0);
        chk("rst_err_underrun", err_ur, 1'b0);
        chk("rst_err_ovf", err_ovf, 1'b0);
        rst_n = 1'b1;
        cyc();

        // Two packets ready at once: delivered whole, in round-robin order
        push(0, 16'h000A, 1'b0); push(0, 16'h000B, 1'b0); push(0, 16'h000C, 1'b1);
        push(2, 16'h000D, 1'b0); push(2, 16'h000E, 1'b1);
        cyc();
        chk("t1_grant0", ch_rd_en, 4'b0001);
        cyc(); cyc();
        chk("t1_empty_before_last", empty, 1'b1);
        cyc();
        chk("t1_empty_after_last", empty, 1'b0);
        chk("t1_head_word", dout, 16'h000A);
        cyc(); cyc(); cyc(); cyc();
        drain(5);
        chk("t1_w0", obuf[0], 16'h000A);
        chk("t1_w1", obuf[1], 16'h000B);
        chk("t1_w2", obuf[2], 16'h000C);
        chk("t1_w3", obuf[3], 16'h000D);
        chk("t1_w4", obuf[4], 16'h000E);
        chk("t1_empty_end", empty, 1'b1);
        chk("t1_no_underrun", err_ur, 1'b0);

        // Half packet is never exposed; reading it flags underrun
        ocnt = 0;
        rd_en = 1'b1;
        push(1, 16'h0011, 1'b0); push(1, 16'h0012, 1'b0);
        for (int i = 0; i < 5; i++) cyc();
        chk("t2_half_pkt_empty", empty, 1'b1);
        chk("t2_err_underrun", err_ur, 1'b1);
        chk("t2_nothing_read", ocnt, 0);
        push(1, 16'h0013, 1'b1);
        drain(3);
        chk("t2_w0", obuf[0], 16'h0011);
        chk("t2_w1", obuf[1], 16'h0012);
        chk("t2_w2", obuf[2], 16'h0013);

        // Limit mode: 10 committed + 4 in flight
        ocnt = 0;
        for (int i = 0; i < 10; i++) push(0, 16'h0100 + 16'(i), (i == 9));
        for (int i = 0; i < 4; i++)  push(1, 16'h0200 + 16'(i), 1'b0);
        for (int i = 0; i < 20; i++) cyc();
        chk("t3_unlimited_not_empty", empty, 1'b0);
        mode_limit = 1'b1;
        #1;
        chk("t3_limit_no_budget_empty", empty, 1'b1);
        for (int i = 0; i < 13; i++) begin
            mode_limit       = tbl[i].mode;
            reg_output_limit = tbl[i].pulse;
            rd_en            = tbl[i].rd;
            cyc();
            chk($sformatf("t3_vec%0d_empty", i), empty, tbl[i].exp_empty);
            chk($sformatf("t3_vec%0d_not_done", i), not_done, tbl[i].exp_nd);
            chk($sformatf("t3_vec%0d_output_limit", i), output_limit, tbl[i].exp_ol);
        end
        reg_output_limit = 1'b0;
        rd_en = 1'b0;
        chk("t3_read_count", ocnt, 10);
        for (int i = 0; i < 10; i++) chk($sformatf("t3_w%0d", i), obuf[i], 16'h0100 + 16'(i));

        // Leaving limit mode drops the remaining budget but keeps output_limit
        ocnt = 0;
        push(1, 16'h0204, 1'b1);
        cyc(); cyc(); cyc();
        mode_limit = 1'b1;
        cyc();
        reg_output_limit = 1'b1;
        cyc();
        reg_output_limit = 1'b0;
        chk("t3b_output_limit", output_limit, 16'd5);
        chk("t3b_not_done", not_done, 1'b1);
        rd_en = 1'b1;
        cyc(); cyc();
        rd_en = 1'b0;
        mode_limit = 1'b0;
        cyc();
        chk("t3b_not_done_cleared", not_done, 1'b0);
        chk("t3b_output_limit_held", output_limit, 16'd5);
        chk("t3b_unlimited_not_empty", empty, 1'b0);
        drain(3);
        for (int i = 0; i < 5; i++) chk($sformatf("t3b_w%0d", i), obuf[i], 16'h0200 + 16'(i));

        // Reset mid-packet and mid-limit-read
        ocnt = 0;
        push(2, 16'h0300, 1'b0); push(2, 16'h0301, 1'b0); push(2, 16'h0302, 1'b1);
        push(3, 16'h0310, 1'b0); push(3, 16'h0311, 1'b0);
        for (int i = 0; i < 9; i++) cyc();
        mode_limit = 1'b1;
        reg_output_limit = 1'b1;
        cyc();
        reg_output_limit = 1'b0;
        chk("t6_pre_output_limit", output_limit, 16'd3);
        rd_en = 1'b1;
        cyc();
        rd_en = 1'b0;
        push(3, 16'h0312, 1'b0);
        #1;
        chk("t6_pre_grant3", ch_rd_en, 4'b1000);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_ch_rd_en", ch_rd_en, 4'b0000);
        chk("t6_rst_empty", empty, 1'b1);
        chk("t6_rst_dout", dout, 16'h0);
        chk("t6_rst_output_limit", output_limit, 16'h0);
        chk("t6_rst_not_done", not_done, 1'b0);
        chk("t6_rst_err_underrun", err_ur, 1'b0);
        chk("t6_rst_err_ovf", err_ovf, 1'b0);
        clear_src();
        mode_limit = 1'b0;
        cyc(); cyc();
        rst_n = 1'b1;
        cyc();

        // Continuous single-word packets on all channels: strict rotation from ch0
        ocnt = 0;
        gcnt = 0;
        for (int k = 0; k < 4; k++) push(k, 16'h0040 + 16'(k), 1'b1);
        for (int k = 0; k < 4; k++) push(k, 16'h0050 + 16'(k), 1'b1);
        for (int i = 0; i < 40 && gcnt < 8; i++) cyc();
        chk("t4_grant_count", gcnt, 8);
        for (int i = 0; i < 8; i++) chk($sformatf("t4_grant%0d", i), glog[i], i % 4);
        cyc();
        drain(8);
        for (int i = 0; i < 8; i++)
            chk($sformatf("t4_w%0d", i), obuf[i],
                (i < 4) ? 16'h0040 + 16'(i) : 16'h0050 + 16'(i - 4));

        // Packet longer than the buffer: overflow flagged, channel stalled, no loss
        gcnt = 0;
        for (int i = 0; i < 20; i++) push(3, 16'h0500 + 16'(i), (i == 19));
        for (int i = 0; i < 25; i++) cyc();
        chk("t5_pops", gcnt, 16);
        chk("t5_src_words_left", tl[3] - hd[3], 4);
        chk("t5_ch_rd_en_stalled", ch_rd_en, 4'b0000);
        chk("t5_err_ovf", err_ovf, 1'b1);
        chk("t5_empty", empty, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

`default_nettype wire
